// File: rtl/program_counter.sv
// program_counter: program address register with single-level interrupt entry/return and optional return stack.
// Optional feature: define CALL_STACK_EN to build the STACK_DEPTH-entry call/return LIFO.
module program_counter #(
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'(2),
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] jaddr,
  input  logic              irq,
  input  logic              reti,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              irq_ack,
  output logic              in_isr,
  output logic              stk_ovf,
  output logic              stk_unf
);
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, pc_inc, pc_seq;
  logic              in_isr_q, in_isr_d, irq_ack_q, irq_ack_d, take_irq;
`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic              ovf_q, ovf_d, unf_q, unf_d, full, empty;
`else
  logic unused_ok;
  assign unused_ok = ret ^ (STACK_DEPTH == 0);
`endif
  always_comb begin
    pc_inc    = pc_q + ADDR_W'(1);
    pc_seq    = (call || load) ? jaddr : pc_inc;
    take_irq  = en && irq && !in_isr_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    in_isr_d  = in_isr_q;
    irq_ack_d = take_irq;
`ifdef CALL_STACK_EN
    sp_m1     = sp_q - SP_W'(1);
    push_idx  = IDX_W'(sp_q);
    pop_idx   = IDX_W'(sp_m1);
    full      = sp_q == SP_W'(STACK_DEPTH);
    empty     = sp_q == '0;
    stack_d   = stack_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
`endif
    if (take_irq) begin
      pc_d     = IRQ_VEC;
      epc_d    = pc_seq;
      in_isr_d = 1'b1;
    end else if (en && reti) begin
      pc_d     = in_isr_q ? epc_q : pc_inc;
      in_isr_d = 1'b0;
    end
`ifdef CALL_STACK_EN
    else if (en && ret) begin
      pc_d  = empty ? pc_inc : stack_q[pop_idx];
      sp_d  = empty ? sp_q : sp_m1;
      unf_d = unf_q || empty;
    end else if (en && call) begin
      pc_d  = jaddr;
      ovf_d = ovf_q || full;
      sp_d  = full ? sp_q : sp_q + SP_W'(1);
      if (!full) stack_d[push_idx] = pc_inc;
    end
`endif
    else if (en && (call || load)) begin
      pc_d = jaddr;
    end else if (en) begin
      pc_d = pc_inc;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      in_isr_q  <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      in_isr_q  <= in_isr_d;
      irq_ack_q <= irq_ack_d;
    end
  end
`ifdef CALL_STACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack_q <= '{default: '0};
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
`else
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif
  assign pc      = pc_q;
  assign irq_ack = irq_ack_q;
  assign in_isr  = in_isr_q;
endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the program address width in bits.
REQ-002 The block SHALL have parameter RESET_VEC, default 0, meaning the PC value after reset.
REQ-003 The block SHALL have parameter IRQ_VEC, default 2, meaning the interrupt service entry address.
REQ-004 The block SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-stack entries.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  advance enable; when 0, all state holds.
REQ-009 load  input  1  jump-taken flag from the jump-condition mux.
REQ-010 jaddr  input  ADDR_W  jump/call target address.
REQ-011 irq  input  1  level interrupt request.
REQ-012 reti  input  1  return-from-interrupt strobe.
REQ-013 call  input  1  subroutine call strobe.
REQ-014 ret  input  1  subroutine return strobe.
REQ-015 pc  output  ADDR_W  current program address (registered).
REQ-016 irq_ack  output  1  one-cycle pulse, interrupt accepted.
REQ-017 in_isr  output  1  high while an interrupt is being serviced.
REQ-018 stk_ovf  output  1  sticky return-stack overflow flag.
REQ-019 stk_unf  output  1  sticky return-stack underflow flag.

Function
REQ-020 With en=1, exactly one action SHALL apply per cycle, in priority order: irq, reti, ret, call, load, increment.
REQ-021 Increment SHALL set pc to pc+1 modulo 2^ADDR_W; the all-ones address SHALL wrap to 0.
REQ-022 The load action SHALL set pc to jaddr.
REQ-023 An irq action (irq=1 and in_isr=0) SHALL set epc to the value pc would have taken absent the irq (jaddr if call or load, else pc+1), set pc to IRQ_VEC, set in_isr to 1, and assert irq_ack for exactly the following cycle.
REQ-024 An irq arriving while in_isr=1 SHALL be ignored (no nesting) and SHALL be accepted on the first enabled cycle after in_isr clears if still asserted.
REQ-025 A reti action with in_isr=1 SHALL set pc to epc and clear in_isr; reti with in_isr=0 SHALL behave as increment.
REQ-026 When en=0, pc, epc, in_isr, the stack and the flags SHALL hold, irq SHALL not be accepted, and irq_ack SHALL be 0.
REQ-027 pc SHALL change only on a clock edge and SHALL be valid one cycle after the inputs are sampled (latency 1).

Reset
REQ-028 Reset SHALL force pc=RESET_VEC, epc=0, in_isr=0, irq_ack=0, stack pointer=0, stk_ovf=0 and stk_unf=0, immediately and independently of clk.
REQ-029 Reset asserted mid-ISR or mid-call SHALL discard epc and all stack contents.

Configuration
REQ-030 With macro CALL_STACK_EN defined, call SHALL push pc+1 onto a STACK_DEPTH-entry LIFO and set pc=jaddr, and ret SHALL pop the top entry into pc.
REQ-031 With CALL_STACK_EN defined, a call with the stack full SHALL still jump, discard the push, and set stk_ovf; a ret with the stack empty SHALL act as increment and set stk_unf; both flags SHALL be cleared only by reset.
REQ-032 Without CALL_STACK_EN, call SHALL act as load (pc=jaddr), ret SHALL be ignored (normal priority continues), no stack storage SHALL exist, and stk_ovf and stk_unf SHALL be tied to 0.

Verification
REQ-033 Reset, then en=1 for 5 cycles with load=0 -> pc sequence 0,1,2,3,4,5.
REQ-034 With ADDR_W=10 and pc=0x3FF, load=0 -> pc=0x000; at pc=5 with load=1 and jaddr=0x120 -> pc=0x120.
REQ-035 At pc=7, irq=1, load=0 -> pc=2, in_isr=1, irq_ack high one cycle; a second irq is ignored; reti -> pc=8, in_isr=0.
REQ-036 At pc=0x10, en=0 with irq=1 and load=1 for 3 cycles -> pc stays 0x10 and irq_ack=0.
REQ-037 With CALL_STACK_EN: 5 nested calls from pc=0x20 to jaddr=0x40 -> stk_ovf=1 after the 5th call; 5 rets -> the 4 stacked addresses are returned in LIFO order, then stk_unf=1.
